imem_loader: RTL
================

# imem_loader

Instruction-memory loader: the write side of the core's instruction-fetch path. It accepts a little-endian byte stream over a valid/ready handshake, packs it into 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory. While loading, it holds the core's PC logic in reset, then releases it with a one-cycle `done` pulse.

## Interface
- `CNT_W`, default 16: width of the word-count input.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  load request; sampled only in IDLE.
- `base_addr`  input  64  byte address of the first word; latched on accepted `start`.
- `num_words`  input  CNT_W  number of 32-bit words to load; latched on accepted `start`.
- `byte_valid`  input  1  source has a byte.
- `byte_data`  input  8  byte value.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `imem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  output  64  byte address of the word being written.
- `imem_wdata`  output  32  word being written.
- `core_hold`  output  1  holds the core's PC/reset path; high while busy.
- `busy`  output  1  state is not IDLE.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  checksum mismatch, sticky; only meaningful with the checksum feature.

## Operation
- States: IDLE, LOAD, CHECK (present only when the checksum feature is compiled in), DONE.
- IDLE:
  - `start`=1 latches `base_addr` and `num_words`, clears the byte index, word counter, running sum and `err`.
  - Next state is LOAD; if `num_words`==0, next state is CHECK (feature on) or DONE.
- LOAD:
  - `byte_ready`=1. A byte transfers when `byte_valid && byte_ready`.
  - Byte k (k = 0..3) of a word goes to bits [8k+7:8k], little-endian.
  - A 2-bit byte index wraps 3→0.
  - On the 4th byte of a word, register `imem_we`=1, `imem_wdata` = the packed word, and `imem_addr` = latched base + 4·word_counter for the next cycle; then increment word_counter.
  - When word_counter reaches `num_words`, go to CHECK or DONE.
- CHECK:
  - `byte_ready`=1. Accept exactly one byte.
  - `err` = (byte ≠ running sum). The running sum is the mod-256 sum of every data byte in the load.
  - Go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `busy` = `core_hold` = (state ≠ IDLE).
- Address arithmetic is 64-bit and wraps modulo 2^64; `base_addr` is not alignment-checked.
- Words are written strictly in ascending address order; no write is ever repeated.
- Reset mid-load:
  - Return to IDLE and discard any partial word.
  - Words already written stay in memory; no further `imem_we` is issued.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=0, `busy`=0, `done`=0, `err`=0.
- `start` accepted in cycle t: `busy`/`core_hold`=1 from t+1.
- 4th byte of a word handshaken in cycle t: `imem_we`=1 with valid addr/data in cycle t+1 only.
  - `imem_addr`/`imem_wdata` hold their values after the strobe.
  - `imem_we` never stalls the byte stream; back-to-back words produce strobes at most every 4 cycles.
- Last byte (data or checksum) in cycle t: state is DONE and `done`=1 in t+1. The final `imem_we` also occurs in t+1 when the checksum feature is off.
  - `busy`/`core_hold` fall in t+2.
- `num_words`=0 with `start` in cycle t: feature off, `done`=1 in t+1. Feature on, CHECK in t+1, then `done` one cycle after the checksum byte.
- Gaps in `byte_valid` stretch LOAD; bytes are never dropped.
- `err` updates in the cycle after the checksum handshake and holds until the next accepted `start` or `reset`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The running 8-bit sum and the CHECK state are built.
  - The stream carries one trailing checksum byte after the data.
  - `err` reports a mismatch.
- Not defined:
  - No CHECK state and no sum logic; `err` is tied to 0.
  - The stream is data bytes only; after the last data byte the FSM goes LOAD→DONE.

## Test plan
- Reset, then `start` with base=0x0, num_words=2, bytes 13 05 A0 00 93 05 10 00 sent back-to-back. Required:
  - `imem_we` pulses twice: addr 0x0 / data 0x00A00513, then addr 0x4 / data 0x00100593.
  - `done` is one pulse; `core_hold` is high from start+1 through DONE.
- Same load with `byte_valid` high one cycle in three → identical writes and data; `done` comes later; no extra strobes.
- `start` with num_words=0 (feature off) → `done`=1 the next cycle, zero `imem_we` pulses, `busy` high exactly one cycle.
- 3-word load to base=0x100, `reset` asserted after byte 6:
  - One write (addr 0x100) occurs; all outputs are 0 in the next cycle.
  - A following 1-word load to base=0x200 writes only addr 0x200.
- `start` pulsed mid-load with base=0x800 → ignored; the original load's addresses and `num_words` complete unchanged.
- Feature on, 1 word 0x00000013 (bytes 13 00 00 00):
  - Checksum byte 0x13 → `err`=0.
  - Checksum byte 0x14 → `err`=1, still held after `done`, cleared on the next `start`.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to 32-bit instruction-memory writer; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [63:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = S_CHECK;
`else
    localparam state_t AFTER_LOAD = S_DONE;
`endif

    state_t           state_q, state_d;
    logic [63:0]      base_q, base_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      word_q, word_d;
    logic             we_q, we_d;
    logic [63:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             hs;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             err_q, err_d;
    assign byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign err        = err_q;
`else
    assign byte_ready = (state_q == S_LOAD);
    assign err        = 1'b0;
`endif

    assign hs         = byte_valid && byte_ready;
    assign busy       = (state_q != S_IDLE);
    assign core_hold  = busy;
    assign done       = (state_q == S_DONE);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    num_d  = num_words;
                    cnt_d  = '0;
                    idx_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = 8'd0;
                    err_d  = 1'b0;
`endif
                    state_d = (num_words == '0) ? AFTER_LOAD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + byte_data;
`endif
                    // Earlier bytes shift down so byte 0 lands in [7:0] once the word is full.
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {byte_data, word_q};
                        addr_d  = base_q + 64'({cnt_q, 2'b00});
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_d == num_q) begin
                            state_d = AFTER_LOAD;
                        end
                    end else begin
                        word_d = {byte_data, word_q[23:8]};
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (hs) begin
                    err_d   = (byte_data != sum_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule
